id_branch_resolver: RTL

- ID-stage counterpart of the IF-stage branch predictor. IF produces predictions; this block consumes them and closes the loop.
- Registers each fetched instruction's prediction into the ID stage and resolves the real branch/jump outcome there.
- Drives the refetch and predictor-update interface back to IF: pre_fch_wrong, real_bjpc, pc_id, ud_BTB, ud_pdt, real_br_taken.
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/id_branch_resolver.sv | 129 ++++++++++++
 1 files changed

// File: rtl/id_branch_resolver.sv
// ID-stage branch resolver: holds the IF prediction of the decoding instruction,
// checks it against the real outcome and drives refetch / predictor-update strobes.
module id_branch_resolver #(
  parameter int          CNT_W       = 16,
  parameter logic [31:0] RESET_PC_ID = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      pc_if,
  input  logic             pre_taken_if,
  input  logic [31:0]      pre_bjpc_if,
  input  logic             wpcir,
  input  logic             flush,
  input  logic             id_stall,
  input  logic             is_cbr,
  input  logic             is_jmp,
  input  logic             br_cond,
  input  logic [31:0]      tgt_id,
  output logic [31:0]      pc_id,
  output logic             pre_fch_wrong,
  output logic [31:0]      real_bjpc,
  output logic             real_br_taken,
  output logic             ud_BTB,
  output logic             ud_pdt,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] miss_cnt
);

  logic             valid_id_q, valid_id_d;
  logic [31:0]      pc_id_q, pc_id_d;
  logic             pt_id_q, pt_id_d;
  logic [31:0]      pbj_id_q, pbj_id_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
  logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

  logic act_taken_s, res_en_s, tmis_s, wrong_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  // Resolve the ID instruction against its prediction; reset forces quiet outputs
  always_comb begin
    act_taken_s = is_jmp | (is_cbr & br_cond);
    res_en_s    = valid_id_q & ~id_stall & ~done_q & (is_cbr | is_jmp);
    tmis_s      = (tgt_id != pbj_id_q);
    wrong_s     = res_en_s & ((act_taken_s ^ pt_id_q) | (act_taken_s & pt_id_q & tmis_s));
    if (rst_n) begin
      real_bjpc = RESET_PC_ID + 32'd4;
    end else if (act_taken_s) begin
      real_bjpc = tgt_id;
    end else begin
      real_bjpc = pc_id_q + 32'd4;
    end
  end

  // Next state of the IF/ID register, done flag and statistics counters
  always_comb begin
    valid_id_d = valid_id_q;
    pc_id_d    = pc_id_q;
    pt_id_d    = pt_id_q;
    pbj_id_d   = pbj_id_q;
    done_d     = done_q;
    if (wpcir) begin
      pc_id_d    = pc_if;
      pt_id_d    = pre_taken_if;
      pbj_id_d   = pre_bjpc_if;
      done_d     = 1'b0;
      valid_id_d = ~(flush | wrong_s);
    end else begin
      if (flush) begin
        valid_id_d = 1'b0;
      end else begin
        valid_id_d = valid_id_q;
      end
      // Marks a held instruction as resolved so strobes fire only once
      if (res_en_s) begin
        done_d = 1'b1;
      end else begin
        done_d = done_q;
      end
    end
    if (res_en_s) begin
      br_cnt_d = sat_inc(br_cnt_q);
    end else begin
      br_cnt_d = br_cnt_q;
    end
    if (wrong_s) begin
      miss_cnt_d = sat_inc(miss_cnt_q);
    end else begin
      miss_cnt_d = miss_cnt_q;
    end
  end

  // State registers; rst_n is an active-high asynchronous reset
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      valid_id_q <= 1'b0;
      pc_id_q    <= RESET_PC_ID;
      pt_id_q    <= 1'b0;
      pbj_id_q   <= 32'h0000_0000;
      done_q     <= 1'b0;
      br_cnt_q   <= {CNT_W{1'b0}};
      miss_cnt_q <= {CNT_W{1'b0}};
    end else begin
      valid_id_q <= valid_id_d;
      pc_id_q    <= pc_id_d;
      pt_id_q    <= pt_id_d;
      pbj_id_q   <= pbj_id_d;
      done_q     <= done_d;
      br_cnt_q   <= br_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign pc_id         = pc_id_q;
  assign pre_fch_wrong = wrong_s;
  assign real_br_taken = res_en_s & act_taken_s;
  assign ud_pdt        = res_en_s & is_cbr;
  assign ud_BTB        = res_en_s & act_taken_s & (~pt_id_q | tmis_s);
  assign br_cnt        = br_cnt_q;
  assign miss_cnt      = miss_cnt_q;

endmodule
